// File: rtl/ldtu_startup_sequencer.sv
// ldtu_startup_sequencer: brings the LiTE-DTU datapath out of reset through calibration
// and sync-pattern alignment to normal running, with registered Moore outputs.
module ldtu_startup_sequencer #(
    parameter int                 Nbits_32    = 32,
    parameter int                 CNT_BITS    = 11,
    parameter int                 RST_CYCLES  = 8,
    parameter int                 CAL_TIMEOUT = 1024,
    parameter int                 ALIGN_MIN   = 64,
    parameter logic [Nbits_32-1:0] SYNC_WORD  = 32'hEAAA_AAAA
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                START,
    input  logic                CAL_BUSY,
    input  logic                handshake,
    output logic                DTU_RST,
    output logic                CAL_REQ,
    output logic                TEST_ENABLE,
    output logic [Nbits_32-1:0] DATA32_ATU_0,
    output logic [Nbits_32-1:0] DATA32_ATU_1,
    output logic [Nbits_32-1:0] DATA32_ATU_2,
    output logic [Nbits_32-1:0] DATA32_ATU_3,
    output logic                READY,
    output logic                CAL_FAIL,
    output logic [2:0]          STATE
);
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RST_DP    = 3'd1,
        CAL_START = 3'd2,
        CAL_WAIT  = 3'd3,
        ALIGN     = 3'd4,
        RUN       = 3'd5,
        FAIL      = 3'd6
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_BITS-1:0]   cnt_q, cnt_d;
    logic                  dtu_rst_q, dtu_rst_d;
    logic                  cal_req_q, cal_req_d;
    logic                  test_enable_q, test_enable_d;
    logic                  ready_q, ready_d;
    logic                  cal_fail_q, cal_fail_d;
    logic [Nbits_32-1:0]   atu_q, atu_d;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (START) state_d = RST_DP;
            RST_DP:    if (cnt_q == CNT_BITS'(RST_CYCLES - 1)) state_d = CAL_START;
            CAL_START: if (CAL_BUSY) state_d = CAL_WAIT;
                       else if (cnt_q == CNT_BITS'(CAL_TIMEOUT - 1)) state_d = FAIL;
            CAL_WAIT:  if (!CAL_BUSY) state_d = ALIGN;
                       else if (cnt_q == CNT_BITS'(CAL_TIMEOUT - 1)) state_d = FAIL;
            ALIGN:     if (handshake && cnt_q >= CNT_BITS'(ALIGN_MIN - 1)) state_d = RUN;
            RUN:       if (START) state_d = RST_DP;
            FAIL:      if (START) state_d = RST_DP;
            default:   state_d = IDLE;
        endcase
        cnt_d         = (state_d != state_q) ? '0 : (&cnt_q ? cnt_q : cnt_q + 1'b1);
        // outputs are decoded from the next state so they switch on the same edge as STATE
        dtu_rst_d     = state_d != RUN;
        cal_req_d     = state_d == CAL_START;
        test_enable_d = state_d == ALIGN;
        ready_d       = state_d == RUN;
        cal_fail_d    = state_d == FAIL;
        atu_d         = (state_d == ALIGN) ? SYNC_WORD : '0;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            dtu_rst_q     <= 1'b1;
            cal_req_q     <= 1'b0;
            test_enable_q <= 1'b0;
            ready_q       <= 1'b0;
            cal_fail_q    <= 1'b0;
            atu_q         <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            dtu_rst_q     <= dtu_rst_d;
            cal_req_q     <= cal_req_d;
            test_enable_q <= test_enable_d;
            ready_q       <= ready_d;
            cal_fail_q    <= cal_fail_d;
            atu_q         <= atu_d;
        end
    end

    assign STATE        = state_q;
    assign DTU_RST      = dtu_rst_q;
    assign CAL_REQ      = cal_req_q;
    assign TEST_ENABLE  = test_enable_q;
    assign READY        = ready_q;
    assign CAL_FAIL     = cal_fail_q;
    assign DATA32_ATU_0 = atu_q;
    assign DATA32_ATU_1 = atu_q;
    assign DATA32_ATU_2 = atu_q;
    assign DATA32_ATU_3 = atu_q;
endmodule

// File: tb/tb_ldtu_startup_sequencer.sv
// tb_ldtu_startup_sequencer: directed stimulus queues each expected state entry (state,
// occupancy of the state just left, output pattern); a negedge monitor checks every entry.
module tb_ldtu_startup_sequencer;
    localparam logic [2:0] S_IDLE = 3'd0, S_RST = 3'd1, S_CALS = 3'd2, S_CALW = 3'd3,
                           S_ALIGN = 3'd4, S_RUN = 3'd5, S_FAIL = 3'd6;
    // {DTU_RST, CAL_REQ, TEST_ENABLE, READY, CAL_FAIL, atu code: 01 sync, 00 zero, 10 other}
    localparam logic [6:0] O_RST = 7'b1000000, O_CALS = 7'b1100000, O_ALIGN = 7'b1010001,
                           O_RUN = 7'b0001000, O_FAIL = 7'b1000100;
    localparam logic [31:0] SYNC = 32'hEAAA_AAAA;

    logic CLK = 1'b0, RST_N = 1'b1, START = 1'b0, CAL_BUSY = 1'b0, handshake = 1'b0;
    logic DTU_RST, CAL_REQ, TEST_ENABLE, READY, CAL_FAIL;
    logic [31:0] DATA32_ATU_0, DATA32_ATU_1, DATA32_ATU_2, DATA32_ATU_3;
    logic [2:0] STATE;

    ldtu_startup_sequencer dut (
        .CLK(CLK), .RST_N(RST_N), .START(START), .CAL_BUSY(CAL_BUSY), .handshake(handshake),
        .DTU_RST(DTU_RST), .CAL_REQ(CAL_REQ), .TEST_ENABLE(TEST_ENABLE),
        .DATA32_ATU_0(DATA32_ATU_0), .DATA32_ATU_1(DATA32_ATU_1),
        .DATA32_ATU_2(DATA32_ATU_2), .DATA32_ATU_3(DATA32_ATU_3),
        .READY(READY), .CAL_FAIL(CAL_FAIL), .STATE(STATE)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [2:0] st;
        int         dur;
        logic [6:0] outs;
    } exp_t;

    exp_t       exp_q[$];
    int         total = 0, bad = 0, occ = 0;
    logic [2:0] prev_st = 3'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [2:0] st, input int dur, input logic [6:0] o);
        exp_t e;
        e.st = st; e.dur = dur; e.outs = o;
        exp_q.push_back(e);
    endtask

    task automatic wait_state(input logic [2:0] s);
        int n = 0;
        while (STATE !== s && n < 5000) begin
            @(negedge CLK);
            n++;
        end
        if (STATE !== s) chk("wait_state_timeout", 32'(STATE), 32'(s));
    endtask

    function automatic logic [6:0] outs_act();
        logic [1:0] a;
        a = (DATA32_ATU_0 === SYNC && DATA32_ATU_1 === SYNC && DATA32_ATU_2 === SYNC &&
             DATA32_ATU_3 === SYNC) ? 2'b01 :
            (DATA32_ATU_0 === '0 && DATA32_ATU_1 === '0 && DATA32_ATU_2 === '0 &&
             DATA32_ATU_3 === '0) ? 2'b00 : 2'b10;
        return {DTU_RST, CAL_REQ, TEST_ENABLE, READY, CAL_FAIL, a};
    endfunction

    always @(negedge CLK) begin
        if (STATE !== prev_st) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_entry: got state %0d expected none", STATE);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("entry_state", 32'(STATE), 32'(e.st));
                if (e.dur >= 0) chk("prev_occupancy", 32'(occ), 32'(e.dur));
                chk("entry_outputs", 32'(outs_act()), 32'(e.outs));
            end
            occ = 1;
        end else begin
            occ++;
        end
        prev_st = STATE;
    end

    initial begin
        #2 RST_N = 1'b0;
        #1;
        chk("async_reset_state", 32'(STATE), 32'(S_IDLE));
        chk("async_reset_outputs", 32'(outs_act()), 32'(O_RST));
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
        chk("idle_hold_state", 32'(STATE), 32'(S_IDLE));
        // nominal run
        push(S_RST, -1, O_RST); push(S_CALS, 8, O_CALS); push(S_CALW, 5, O_RST);
        push(S_ALIGN, 200, O_ALIGN); push(S_RUN, 64, O_RUN);
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        wait_state(S_CALS);
        repeat (4) @(negedge CLK);
        CAL_BUSY = 1'b1;
        repeat (200) @(negedge CLK);
        CAL_BUSY = 1'b0;
        wait_state(S_ALIGN);
        repeat (10) @(negedge CLK);
        handshake = 1'b1;
        // CAL_BUSY ignored in RUN, then restart with START held through ALIGN
        wait_state(S_RUN);
        CAL_BUSY = 1'b1;
        repeat (3) @(negedge CLK);
        CAL_BUSY = 1'b0;
        repeat (2) @(negedge CLK);
        push(S_RST, 6, O_RST); push(S_CALS, 8, O_CALS); push(S_CALW, 1, O_RST);
        push(S_ALIGN, 1, O_ALIGN); push(S_RUN, 64, O_RUN);
        START = 1'b1;
        wait_state(S_CALS);
        CAL_BUSY = 1'b1;
        wait_state(S_CALW);
        CAL_BUSY = 1'b0;
        wait_state(S_ALIGN);
        START = 1'b0;
        // early handshake is not latched
        wait_state(S_RUN);
        handshake = 1'b0;
        push(S_RST, 1, O_RST); push(S_CALS, 8, O_CALS); push(S_CALW, 1, O_RST);
        push(S_ALIGN, 1, O_ALIGN); push(S_RUN, 101, O_RUN);
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        wait_state(S_CALS);
        CAL_BUSY = 1'b1;
        wait_state(S_CALW);
        CAL_BUSY = 1'b0;
        wait_state(S_ALIGN);
        handshake = 1'b1;
        repeat (63) @(negedge CLK);
        handshake = 1'b0;
        repeat (37) @(negedge CLK);
        handshake = 1'b1;
        wait_state(S_RUN);
        handshake = 1'b0;
        // CAL_BUSY stuck low -> timeout in CAL_START, then recovery
        push(S_RST, 1, O_RST); push(S_CALS, 8, O_CALS); push(S_FAIL, 1024, O_FAIL);
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        wait_state(S_FAIL);
        repeat (3) @(negedge CLK);
        push(S_RST, 4, O_RST);
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        // tie at last CAL_START cycle, then CAL_BUSY stuck high -> timeout in CAL_WAIT
        push(S_CALS, 8, O_CALS); push(S_CALW, 1024, O_RST); push(S_FAIL, 1024, O_FAIL);
        wait_state(S_CALS);
        repeat (1023) @(negedge CLK);
        CAL_BUSY = 1'b1;
        wait_state(S_FAIL);
        CAL_BUSY = 1'b0;
        // asynchronous reset in the middle of CAL_WAIT
        push(S_RST, 1, O_RST); push(S_CALS, 8, O_CALS); push(S_CALW, 1, O_RST);
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        wait_state(S_CALS);
        CAL_BUSY = 1'b1;
        wait_state(S_CALW);
        repeat (10) @(negedge CLK);
        push(S_IDLE, -1, O_RST);
        #2 RST_N = 1'b0;
        #1;
        chk("midcal_reset_state", 32'(STATE), 32'(S_IDLE));
        chk("midcal_reset_outputs", 32'(outs_act()), 32'(O_RST));
        @(posedge CLK);
        @(posedge CLK);
        #3 RST_N = 1'b1;
        CAL_BUSY = 1'b0;
        repeat (20) @(negedge CLK);
        chk("post_reset_state", 32'(STATE), 32'(S_IDLE));
        chk("post_reset_dtu_rst", 32'(DTU_RST), 32'd1);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
